// File: rtl/tracesys_capture_pkg.sv
// rtl/tracesys_capture_pkg.sv - shared types and defaults for the trace capture controller
//
// Purpose: capture FSM state encoding and default RAM geometry.
// Contents:
//   state_t      - IDLE=0 ARMED=1 POST=2 DONE=3 (matches status_state)
//   DEF_ADDR_W   - default RAM address width
//   DEF_DATA_W   - default capture/RAM data width

package tracesys_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/tracesys_capture_wr_ptr.sv
// rtl/tracesys_capture_wr_ptr.sv - wrapping capture write pointer with sticky wrap flag
//
// Purpose: next capture write address; wraps 2**ADDR_W-1 -> 0 and records the wrap.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   i_clr          - clear pointer and wrap flag (has priority over i_inc)
//   i_inc          - advance pointer by one
//   o_ptr          - current pointer
//   o_wrapped      - set on the first wrap since the last clear
// Parameters:
//   ADDR_W         - pointer width
//   STICKY_WRAP    - 0 suppresses the wrap flag entirely

module tracesys_capture_wr_ptr #(
    parameter int ADDR_W      = 8,
    parameter bit STICKY_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_wrapped
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_wrapped;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (i_clr) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
            if (STICKY_WRAP && (r_ptr == '1)) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign o_ptr     = r_ptr;
    assign o_wrapped = r_wrapped;

endmodule

// File: rtl/tracesys_capture_ctrl.sv
// rtl/tracesys_capture_ctrl.sv - trace capture sequencer and RAM write-port arbiter
//
// Purpose: runs the arm/trigger/post-trigger capture cycle and shares the RAM
// write port between the capture stream (ARMED/POST) and the CSR host (IDLE/DONE).
// Optional build macro: TRACESYS_CAPTURE_CTRL_STOP_ON_FULL_EN - when defined,
// an untriggered capture stops in DONE after writing the last RAM address
// instead of wrapping.
// Ports:
//   clk, reset_n                    - clock, synchronous active-low reset
//   cfg_arm, cfg_abort              - one-cycle control pulses
//   cfg_post_count                  - beats stored after the trigger beat
//   st_valid/st_data/st_trig/st_ready - capture stream
//   host_write/host_address/host_writedata/host_waitrequest - CSR host writes
//   ram_wr_*                        - registered RAM write port
//   status_*                        - state, trigger address, pointer, wrap flag
//   done_pulse                      - one cycle, coincident with the final capture write

module tracesys_capture_ctrl
    import tracesys_capture_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_post_count,
    input  logic              st_valid,
    input  logic [DATA_W-1:0] st_data,
    input  logic              st_trig,
    output logic              st_ready,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_writedata,
    output logic              host_waitrequest,
    output logic [ADDR_W-1:0] ram_wr_address,
    output logic [DATA_W-1:0] ram_wr_writedata,
    output logic              ram_wr_write,
    input  logic              ram_wr_waitrequest,
    output logic [1:0]        status_state,
    output logic [ADDR_W-1:0] status_trig_addr,
    output logic [ADDR_W-1:0] status_wr_ptr,
    output logic              status_wrapped,
    output logic              done_pulse
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_wr_address;
    logic [DATA_W-1:0] r_wr_writedata;
    logic              r_wr_write;
    logic              r_done_pulse;

    logic [ADDR_W-1:0] w_wr_ptr;
    logic              w_wrapped;
    logic              w_capturing;
    logic              w_cap_wr;
    logic              w_host_wr;
    logic              w_trig_hit;
    logic              w_arm_ok;
    logic              w_full_stop;
    logic              w_enter_done;

    // Stream owns the write port while capturing, the host otherwise.
    assign w_capturing      = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign st_ready         = w_capturing ? !ram_wr_waitrequest : 1'b1;
    assign host_waitrequest = w_capturing | ram_wr_waitrequest;

    // Beats accepted in IDLE/DONE are dropped; only capturing beats write.
    assign w_cap_wr  = st_valid & st_ready & w_capturing;
    assign w_host_wr = host_write & !host_waitrequest;

    // Abort wins over trigger and arm, but the accepted beat is still written.
    assign w_trig_hit = (r_state == ST_ARMED) & w_cap_wr & st_trig & !cfg_abort;
    assign w_arm_ok   = cfg_arm & !cfg_abort & ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef TRACESYS_CAPTURE_CTRL_STOP_ON_FULL_EN
    localparam bit STICKY_WRAP = 1'b0;
    assign w_full_stop = (r_state == ST_ARMED) & w_cap_wr & !st_trig & (w_wr_ptr == '1);
`else
    localparam bit STICKY_WRAP = 1'b1;
    assign w_full_stop = 1'b0;
`endif

    tracesys_capture_wr_ptr #(
        .ADDR_W      (ADDR_W),
        .STICKY_WRAP (STICKY_WRAP)
    ) u_wr_ptr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_arm_ok),
        .i_inc     (w_cap_wr),
        .o_ptr     (w_wr_ptr),
        .o_wrapped (w_wrapped)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (cfg_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_arm) begin
                        w_next_state = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        w_next_state = (cfg_post_count == '0) ? ST_DONE : ST_POST;
                    end else if (w_full_stop) begin
                        w_next_state = ST_DONE;
                    end
                end
                ST_POST: begin
                    if (w_cap_wr && (r_post_cnt == ADDR_W'(1))) begin
                        w_next_state = ST_DONE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    assign w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
        end else begin
            if (w_trig_hit) begin
                r_post_cnt <= cfg_post_count;
            end else if ((r_state == ST_POST) && w_cap_wr) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end

            if (w_arm_ok) begin
                r_trig_addr <= '0;
            end else if (w_trig_hit) begin
                r_trig_addr <= w_wr_ptr;
            end
        end
    end

    // Write port is registered so done_pulse lines up with the last capture write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_write     <= 1'b0;
            r_wr_address   <= '0;
            r_wr_writedata <= '0;
            r_done_pulse   <= 1'b0;
        end else begin
            r_wr_write   <= w_cap_wr | w_host_wr;
            r_done_pulse <= w_enter_done;
            if (w_cap_wr) begin
                r_wr_address   <= w_wr_ptr;
                r_wr_writedata <= st_data;
            end else if (w_host_wr) begin
                r_wr_address   <= host_address;
                r_wr_writedata <= host_writedata;
            end
        end
    end

    assign ram_wr_write     = r_wr_write;
    assign ram_wr_address   = r_wr_address;
    assign ram_wr_writedata = r_wr_writedata;
    assign done_pulse       = r_done_pulse;
    assign status_state     = r_state;
    assign status_trig_addr = r_trig_addr;
    assign status_wr_ptr    = w_wr_ptr;
    assign status_wrapped   = w_wrapped;

endmodule

// File: tb/tb_tracesys_capture_ctrl.sv
// tb/tb_tracesys_capture_ctrl.sv - directed self-checking bench for tracesys_capture_ctrl

module tb_tracesys_capture_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_arm;
    logic          cfg_abort;
    logic [AW-1:0] cfg_post_count;
    logic          st_valid;
    logic [DW-1:0] st_data;
    logic          st_trig;
    logic          st_ready;
    logic          host_write;
    logic [AW-1:0] host_address;
    logic [DW-1:0] host_writedata;
    logic          host_waitrequest;
    logic [AW-1:0] ram_wr_address;
    logic [DW-1:0] ram_wr_writedata;
    logic          ram_wr_write;
    logic          ram_wr_waitrequest;
    logic [1:0]    status_state;
    logic [AW-1:0] status_trig_addr;
    logic [AW-1:0] status_wr_ptr;
    logic          status_wrapped;
    logic          done_pulse;

    int n_vec  = 0;
    int n_miss = 0;

    logic [AW-1:0] mon_addr[$];
    logic [DW-1:0] mon_data[$];

    tracesys_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cfg_arm            (cfg_arm),
        .cfg_abort          (cfg_abort),
        .cfg_post_count     (cfg_post_count),
        .st_valid           (st_valid),
        .st_data            (st_data),
        .st_trig            (st_trig),
        .st_ready           (st_ready),
        .host_write         (host_write),
        .host_address       (host_address),
        .host_writedata     (host_writedata),
        .host_waitrequest   (host_waitrequest),
        .ram_wr_address     (ram_wr_address),
        .ram_wr_writedata   (ram_wr_writedata),
        .ram_wr_write       (ram_wr_write),
        .ram_wr_waitrequest (ram_wr_waitrequest),
        .status_state       (status_state),
        .status_trig_addr   (status_trig_addr),
        .status_wr_ptr      (status_wr_ptr),
        .status_wrapped     (status_wrapped),
        .done_pulse         (done_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_wr_write === 1'b1) begin
            mon_addr.push_back(ram_wr_address);
            mon_data.push_back(ram_wr_writedata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic t);
        st_valid = 1'b1;
        st_data  = d;
        st_trig  = t;
        step();
        st_valid = 1'b0;
        st_trig  = 1'b0;
    endtask

    task automatic arm();
        cfg_arm = 1'b1;
        step();
        cfg_arm = 1'b0;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n            = 1'b0;
        cfg_arm            = 1'b0;
        cfg_abort          = 1'b0;
        cfg_post_count     = '0;
        st_valid           = 1'b0;
        st_data            = '0;
        st_trig            = 1'b0;
        host_write         = 1'b0;
        host_address       = '0;
        host_writedata     = '0;
        ram_wr_waitrequest = 1'b0;
        step();
        step();

        // reset state
        chk("rst_state", status_state, 0);
        chk("rst_write", ram_wr_write, 0);
        chk("rst_addr", ram_wr_address, 0);
        chk("rst_data", ram_wr_writedata, 0);
        chk("rst_trig_addr", status_trig_addr, 0);
        chk("rst_wr_ptr", status_wr_ptr, 0);
        chk("rst_wrapped", status_wrapped, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_host_wait", host_waitrequest, 0);
        reset_n = 1'b1;

        // RAM init busy stalls the host
        ram_wr_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("init_host_wait", host_waitrequest, 1);
            step();
            chk("init_no_write", ram_wr_write, 0);
        end
        ram_wr_waitrequest = 1'b0;
        host_write     = 1'b1;
        host_address   = 4'd3;
        host_writedata = 8'hA5;
        #1;
        chk("host_wait_released", host_waitrequest, 0);
        step();
        host_write = 1'b0;
        chk("host_write", ram_wr_write, 1);
        chk("host_addr", ram_wr_address, 3);
        chk("host_data", ram_wr_writedata, 8'hA5);
        step();
        chk("host_single_pulse", ram_wr_write, 0);
        chk("host_mon_count", mon_addr.size(), 1);
        clear_mon();

        // trigger capture with two post beats
        cfg_post_count = 4'd2;
        arm();
        chk("t2_armed", status_state, 1);
        beat(8'h10, 1'b0);
        beat(8'h11, 1'b0);
        chk("t2_still_armed", status_state, 1);
        beat(8'h12, 1'b1);
        chk("t2_post", status_state, 2);
        chk("t2_trig_addr", status_trig_addr, 2);
        beat(8'h13, 1'b0);
        chk("t2_post2", status_state, 2);
        chk("t2_no_done_yet", done_pulse, 0);
        beat(8'h14, 1'b0);
        chk("t2_done", status_state, 3);
        chk("t2_done_pulse", done_pulse, 1);
        chk("t2_last_write", ram_wr_write, 1);
        chk("t2_last_addr", ram_wr_address, 4);
        chk("t2_last_data", ram_wr_writedata, 8'h14);
        st_valid = 1'b1;
        st_data  = 8'h15;
        #1;
        chk("t2_done_ready", st_ready, 1);
        step();
        st_valid = 1'b0;
        chk("t2_discard_write", ram_wr_write, 0);
        chk("t2_done_pulse_once", done_pulse, 0);
        chk("t2_ptr_hold", status_wr_ptr, 5);
        step();
        chk("t2_mon_count", mon_addr.size(), 5);
        for (int i = 0; i < 5 && i < mon_addr.size(); i++) begin
            chk("t2_mon_addr", mon_addr[i], i);
            chk("t2_mon_data", mon_data[i], 8'h10 + i);
        end

`ifndef TRACESYS_CAPTURE_CTRL_STOP_ON_FULL_EN
        // untriggered wrap
        clear_mon();
        arm();
        chk("t3_armed", status_state, 1);
        chk("t3_trig_cleared", status_trig_addr, 0);
        chk("t3_ptr_cleared", status_wr_ptr, 0);
        host_write     = 1'b1;
        host_address   = 4'd7;
        host_writedata = 8'h99;
        #1;
        chk("t3_host_blocked", host_waitrequest, 1);
        step();
        host_write = 1'b0;
        chk("t3_host_no_write", ram_wr_write, 0);
        ram_wr_waitrequest = 1'b1;
        st_valid = 1'b1;
        st_data  = 8'h55;
        #1;
        chk("t3_stall_ready", st_ready, 0);
        step();
        chk("t3_stall_ptr", status_wr_ptr, 0);
        chk("t3_stall_no_write", ram_wr_write, 0);
        chk("t3_stall_state", status_state, 1);
        ram_wr_waitrequest = 1'b0;
        st_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(8'(i), 1'b0);
            if (i == 14) chk("t3_not_wrapped_yet", status_wrapped, 0);
        end
        chk("t3_wrapped", status_wrapped, 1);
        chk("t3_wr_ptr", status_wr_ptr, 4);
        chk("t3_state", status_state, 1);
        step();
        chk("t3_mon_count", mon_addr.size(), 20);
        if (mon_addr.size() == 20) begin
            chk("t3_last_addr", mon_addr[19], 3);
            chk("t3_last_data", mon_data[19], 8'h13);
        end
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("t3_abort_idle", status_state, 0);
`endif

        // zero post count
        clear_mon();
        cfg_post_count = 4'd0;
        arm();
        beat(8'h77, 1'b1);
        chk("t4_done", status_state, 3);
        chk("t4_done_pulse", done_pulse, 1);
        chk("t4_addr", ram_wr_address, 0);
        chk("t4_data", ram_wr_writedata, 8'h77);
        chk("t4_trig_addr", status_trig_addr, 0);
        chk("t4_wrapped_cleared", status_wrapped, 0);
        step();
        chk("t4_done_pulse_once", done_pulse, 0);
        chk("t4_mon_count", mon_addr.size(), 1);

        // abort + arm in POST
        cfg_post_count = 4'd3;
        arm();
        beat(8'h20, 1'b1);
        chk("t5_post", status_state, 2);
        cfg_abort = 1'b1;
        cfg_arm   = 1'b1;
        st_valid  = 1'b1;
        st_data   = 8'h21;
        step();
        cfg_abort = 1'b0;
        cfg_arm   = 1'b0;
        st_valid  = 1'b0;
        #1;
        chk("t5_idle", status_state, 0);
        chk("t5_host_wait", host_waitrequest, 0);
        chk("t5_abort_beat_write", ram_wr_write, 1);
        chk("t5_abort_beat_addr", ram_wr_address, 1);
        chk("t5_abort_beat_data", ram_wr_writedata, 8'h21);
        chk("t5_ptr_kept", status_wr_ptr, 2);
        chk("t5_no_done", done_pulse, 0);
        step();

`ifdef TRACESYS_CAPTURE_CTRL_STOP_ON_FULL_EN
        // stop on full
        arm();
        for (int i = 0; i < 15; i++) beat(8'(i), 1'b0);
        chk("t6_armed", status_state, 1);
        beat(8'hF0, 1'b0);
        chk("t6_done", status_state, 3);
        chk("t6_done_pulse", done_pulse, 1);
        chk("t6_last_addr", ram_wr_address, 15);
        chk("t6_wrapped", status_wrapped, 0);
        chk("t6_trig_addr", status_trig_addr, 0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
